// File: rtl/subtractor_seq.sv
// Digit-serial subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Ports: clk, rst_n, in_valid/in_ready/a/b/bin, out_valid/out_ready/diff/bout,
//   busy, ovf (signed overflow, only when SUB_OVF_FLAG_EN is defined).
module subtractor_seq #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic               borrow;
  logic [IW-1:0]      idx;

  logic [DIGIT-1:0]   sa;
  logic [DIGIT-1:0]   sb;
  logic [DIGIT:0]     sum;
  logic [WIDTH-1:0]   mask;
  logic [WIDTH-1:0]   diff_nxt;
  logic               last;
  logic               idx_ok;
  logic               accept;

  assign in_ready  = rst_n &
                     ((state == IDLE) |
                      ((state == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign bout      = borrow;

  assign idx_ok = (int'(idx) < NDIG);
  assign last   = (int'(idx) == NDIG - 1);

  // a - b - bin == a + ~b + ~borrow per slice;
  // carry out of a slice means no borrow.
  always_comb begin
    sa       = DIGIT'(a_r >> (int'(idx) * DIGIT));
    sb       = DIGIT'(b_r >> (int'(idx) * DIGIT));
    sum      = {1'b0, sa} + {1'b0, ~sb} +
               {{DIGIT{1'b0}}, ~borrow};
    mask     = WIDTH'({DIGIT{1'b1}}) << (int'(idx) * DIGIT);
    diff_nxt = (diff & ~mask) |
               (WIDTH'(sum[DIGIT-1:0]) << (int'(idx) * DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      borrow <= 1'b0;
      idx    <= '0;
      diff   <= '0;
`ifdef SUB_OVF_FLAG_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            state  <= RUN;
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            idx    <= '0;
            diff   <= '0;
`ifdef SUB_OVF_FLAG_EN
            ovf    <= 1'b0;
`endif
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (!idx_ok) begin
            state <= IDLE;
            idx   <= '0;
          end else begin
            diff   <= diff_nxt;
            borrow <= ~sum[DIGIT];
            if (last) begin
              state <= DONE;
`ifdef SUB_OVF_FLAG_EN
              ovf   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) &
                       (diff_nxt[WIDTH-1] ^ a_r[WIDTH-1]);
`endif
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
